muldiv_ctrl: RTL and testbench

- Sequencer for the RV32M execute path. Accepts one M-extension op at a time from the EX stage.
- MUL/MULH/MULHSU/MULHU: drives the clocked 33x33 signed multiplier (external datapath) and selects the result half.
- DIV/DIVU/REM/REMU: runs an internal radix-2 restoring divider.
- Returns a registered result with a one-cycle done pulse; busy_o stalls the pipeline.

---
 rtl/muldiv_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: drives an external clocked 33x33 multiplier and runs a radix-2 restoring divider.
// Optional `MULDIV_FAST_SPECIAL_EN` short-circuits divide-by-zero, signed overflow and divide-by-one.
module muldiv_ctrl #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic [32:0] mul_a_o,
    output logic [32:0] mul_b_o,
    input  logic [65:0] mul_res_i
);
    typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE} state_t;

    localparam logic [5:0] MUL_LAT_C = 6'(MUL_LAT);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [32:0] mul_a_q, mul_a_d;
    logic [32:0] mul_b_q, mul_b_d;
`ifdef MULDIV_FAST_SPECIAL_EN
    logic        one_q, one_d;
`endif

    logic        signed_op;
    logic [31:0] abs1, abs2;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic        unused_res_bits;

    assign unused_res_bits = ^mul_res_i[65:64];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
`ifdef MULDIV_FAST_SPECIAL_EN
        one_d     = one_q;
`endif
        signed_op = ~op_i[0];
        abs1      = (signed_op && rs1_i[31]) ? -rs1_i : rs1_i;
        abs2      = (signed_op && rs2_i[31]) ? -rs2_i : rs2_i;
        shifted   = {rem_q, quo_q[31]};
        diff      = {1'b0, shifted} - {2'b00, dvsr_q};

        case (state_q)
            IDLE: begin
                if (start_i && !kill_i) begin
                    op_d   = op_i;
                    a_d    = rs1_i;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (!op_i[2]) begin
                        mul_a_d = {(op_i != 3'd3) && rs1_i[31], rs1_i};
                        mul_b_d = {(op_i < 3'd2) && rs2_i[31], rs2_i};
                        state_d = MUL_WAIT;
                    end else begin
                        quo_d     = abs1;
                        rem_d     = '0;
                        dvsr_d    = abs2;
                        neg_quo_d = signed_op && (rs1_i[31] ^ rs2_i[31]);
                        neg_rem_d = signed_op && rs1_i[31];
                        dz_d      = (rs2_i == 32'd0);
                        ovf_d     = signed_op && (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_SPECIAL_EN
                        one_d   = (rs2_i == 32'd1);
                        state_d = (dz_d || ovf_d || one_d) ? DIV_FIX : DIV_RUN;
`else
                        state_d = DIV_RUN;
`endif
                    end
                end
            end
            MUL_WAIT: begin
                if (kill_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == MUL_LAT_C) begin
                    result_d = (op_q == 3'd0) ? mul_res_i[31:0] : mul_res_i[63:32];
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DIV_RUN: begin
                if (kill_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    // Restoring step: keep the trial subtraction only when it did not borrow.
                    if (!diff[33]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    if (cnt_q == 6'd31) begin
                        cnt_d   = '0;
                        state_d = DIV_FIX;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            DIV_FIX: begin
                if (kill_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == 6'd0) begin
                    // First fix cycle settles the signed quotient/remainder, second one publishes.
                    cnt_d = 6'd1;
                    if (dz_q) begin
                        quo_d = 32'hFFFF_FFFF;
                        rem_d = a_q;
                    end else if (ovf_q) begin
                        quo_d = 32'h8000_0000;
                        rem_d = '0;
`ifdef MULDIV_FAST_SPECIAL_EN
                    end else if (one_q) begin
                        quo_d = a_q;
                        rem_d = '0;
`endif
                    end else begin
                        quo_d = neg_quo_q ? -quo_q : quo_q;
                        rem_d = neg_rem_q ? -rem_q : rem_q;
                    end
                end else begin
                    result_d = op_q[1] ? rem_q : quo_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
`ifdef MULDIV_FAST_SPECIAL_EN
            one_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
`ifdef MULDIV_FAST_SPECIAL_EN
            one_q     <= one_d;
`endif
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign mul_a_o  = mul_a_q;
    assign mul_b_o  = mul_b_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural RV32M model plus directed literal cases and random traffic.
module tb_muldiv_ctrl;
    localparam int LAT = 1;
`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int LAT_SP = 2;
`else
    localparam int LAT_SP = 34;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        kill_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [32:0] mul_a_o;
    logic [32:0] mul_b_o;
    logic [65:0] mul_res_i;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .kill_i(kill_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_res_i(mul_res_i)
    );

    // External multiplier: LAT-stage registered signed 33x33 product.
    logic [65:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= 66'($signed(mul_a_o) * $signed(mul_b_o));
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_res_i = pipe[LAT-1];

    function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return LAT + 1;
`ifdef MULDIV_FAST_SPECIAL_EN
        if (b == 0 || b == 1 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
        return 34;
    endfunction

    // Behavioural model: busy from accept through done cycle, done after a fixed op latency.
    logic        m_busy, m_done, m_is_mul;
    logic [31:0] m_result, m_pend;
    logic [32:0] m_mul_a, m_mul_b;
    int          m_cnt, m_lat;
    int          m_accepts = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_is_mul = 0; m_result = 0; m_cnt = 0;
            m_mul_a = 0; m_mul_b = 0;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy) begin
            if (kill_i) m_busy = 0;
            else begin
                m_cnt++;
                if (m_cnt == m_lat) begin
                    m_done = 1;
                    m_result = m_pend;
                end
            end
        end else if (start_i && !kill_i) begin
            m_busy = 1;
            m_cnt = 0;
            m_pend = refResult(op_i, rs1_i, rs2_i);
            m_lat = refLatency(op_i, rs1_i, rs2_i);
            m_is_mul = !op_i[2];
            m_accepts++;
            if (!op_i[2]) begin
                m_mul_a = {(op_i != 3'd3) && rs1_i[31], rs1_i};
                m_mul_b = {(op_i < 3'd2) && rs2_i[31], rs2_i};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("busy", 66'(busy_o), 66'(m_busy));
            checkOutput("done", 66'(done_o), 66'(m_done));
            checkOutput("result", 66'(result_o), 66'(m_result));
            if (m_busy && m_is_mul) begin
                checkOutput("mul_a", 66'(mul_a_o), 66'(m_mul_a));
                checkOutput("mul_b", 66'(mul_b_o), 66'(m_mul_b));
            end
            if (done_o) done_seen++;
        end
    end

    task automatic waitIdle();
        int i;
        i = 0;
        while (busy_o && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (busy_o) checkOutput("idle_timeout", 66'(busy_o), 66'(0));
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, output logic [32:0] got_mul_a);
        int n;
        waitIdle();
        start_i = 1; op_i = op; rs1_i = a; rs2_i = b;
        @(posedge clk);
        @(negedge clk);
        start_i = 0; op_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
        got_mul_a = mul_a_o;
        n = 0;
        while (!done_o && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkOutput({name, "_result"}, 66'(result_o), 66'(exp));
        checkOutput({name, "_latency"}, 66'(n), 66'(exp_lat));
    endtask

    task automatic applyStimulus(input bit allow_kill);
        logic [31:0] r;
        start_i = ($urandom_range(0, 1) == 1);
        op_i = 3'($urandom);
        r = $urandom;
        rs1_i = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : r;
        case ($urandom_range(0, 7))
            0: rs2_i = 32'd0;
            1: rs2_i = 32'd1;
            2: rs2_i = 32'hFFFF_FFFF;
            default: rs2_i = $urandom;
        endcase
        kill_i = allow_kill && ($urandom_range(0, 39) == 0);
        rst = allow_kill && ($urandom_range(0, 499) == 0);
    endtask

    initial begin
        logic [32:0] ma;
        int seen, acc0, done0;
        rst = 1; start_i = 0; kill_i = 0; op_i = 0; rs1_i = 0; rs2_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 66'(busy_o), 66'(0));
        checkOutput("reset_done", 66'(done_o), 66'(0));
        checkOutput("reset_result", 66'(result_o), 66'(0));
        checkOutput("reset_mul_a", 66'(mul_a_o), 66'(0));
        checkOutput("reset_mul_b", 66'(mul_b_o), 66'(0));
        rst = 0;
        mon_en = 1;

        runOp("mul", 3'd0, 32'h6, 32'h3, 32'h12, LAT + 1, ma);
        checkOutput("mul_a_ext", 66'(ma), 66'(33'h0_0000_0006));
        runOp("mulh", 3'd1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, LAT + 1, ma);
        checkOutput("mulh_a_ext", 66'(ma), 66'(33'h1_FFFF_FFF9));
        runOp("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT + 1, ma);
        checkOutput("mulhu_a_ext", 66'(ma), 66'(33'h0_FFFF_FFFF));
        runOp("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, LAT + 1, ma);
        runOp("div", 3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 34, ma);
        runOp("rem", 3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 34, ma);
        runOp("divu", 3'd5, 32'd100, 32'd7, 32'd14, 34, ma);
        runOp("remu", 3'd7, 32'd100, 32'd7, 32'd2, 34, ma);
        runOp("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SP, ma);
        runOp("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, LAT_SP, ma);
        runOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP, ma);
        runOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_SP, ma);
        runOp("divu_by1", 3'd5, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, LAT_SP, ma);

        // Kill a long division part-way; no completion may follow.
        waitIdle();
        start_i = 1; op_i = 3'd4; rs1_i = 32'd100; rs2_i = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start_i = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill_i = 1;
        @(posedge clk);
        @(negedge clk);
        kill_i = 0;
        checkOutput("kill_busy", 66'(busy_o), 66'(0));
        checkOutput("kill_result", 66'(result_o), 66'(32'hDEAD_BEEF));
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        checkOutput("kill_no_done", 66'(seen), 66'(0));
        runOp("mul_after_kill", 3'd0, 32'h6, 32'h3, 32'h12, LAT + 1, ma);

        // Continuous start requests with alternating op classes.
        waitIdle();
        @(negedge clk);
        acc0 = m_accepts;
        done0 = done_seen;
        for (int i = 0; i < 300; i++) begin
            start_i = 1;
            op_i = (i % 2 == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            rs1_i = $urandom;
            rs2_i = $urandom;
            @(negedge clk);
        end
        start_i = 0;
        waitIdle();
        @(negedge clk);
        checkOutput("stream_done_count", 66'(done_seen - done0), 66'(m_accepts - acc0));

        // Random traffic with occasional kills and synchronous resets.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(1'b1);
            @(negedge clk);
        end
        start_i = 0; kill_i = 0; rst = 0;
        waitIdle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
